// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scanner
package seg_pkg;
  localparam logic AN_OFF = 1'b1;
  localparam int DEF_N_DIGITS = 4;
  localparam int DEF_SLOT_CYC = 50000;
  localparam int DEF_BLANK_CYC = 500;
  typedef logic [3:0] nib_t;
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot cycle counter and digit selector with look-ahead flags
module seg_slot_timer import seg_pkg::*; #(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic boundary,
  output logic [$clog2(N_DIGITS)-1:0] sel_nx,
  output logic blank_nx
);
  localparam int CW = $clog2(SLOT_CYC);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLK = CW'(BLANK_CYC);
  localparam logic [SW-1:0] LAST_SEL = SW'(N_DIGITS - 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] sel;
  // next counter/selector values so the top can register outputs that match the upcoming cycle
  always_comb begin
    tick = cnt == LAST_CNT;
    boundary = tick && sel == LAST_SEL;
    cnt_nx = tick ? '0 : cnt + 1'b1;
    sel_nx = tick ? (sel == LAST_SEL ? '0 : sel + 1'b1) : sel;
    blank_nx = cnt_nx < BLK;
  end
  // counter and selector state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= '0;
    end else begin
      cnt <= cnt_nx;
      sel <= sel_nx;
    end
  end
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered multiplexed scanner for a common-anode display
module seg_scan_mux import seg_pkg::*; #(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic load,
  input  logic blank_lz,
  output nib_t digit_nib,
  output logic [N_DIGITS-1:0] an,
  output logic dp,
  output logic frame_done
);
  localparam int W = 4 * N_DIGITS;
  localparam int SW = $clog2(N_DIGITS);
  logic tick, boundary, blank_nx, en;
  logic [SW-1:0] sel_nx;
  logic [W-1:0] pend_val, disp, disp_nx;
  logic [N_DIGITS-1:0] pend_dp, disp_dp, disp_dp_nx, zlz;
  logic pend_vld;
  nib_t nib_nx;
  seg_slot_timer #(.N_DIGITS(N_DIGITS), .SLOT_CYC(SLOT_CYC), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .boundary(boundary),
    .sel_nx(sel_nx),
    .blank_nx(blank_nx)
  );
  // next display contents, leading-zero map and enable for the digit about to be shown
  always_comb begin
    disp_nx = !boundary ? disp : load ? value : pend_vld ? pend_val : disp;
    disp_dp_nx = !boundary ? disp_dp : load ? dp_in : pend_vld ? pend_dp : disp_dp;
    zlz = '0;
    zlz[N_DIGITS-1] = disp_nx[W-1 -: 4] == 4'h0;
    for (int i = N_DIGITS - 2; i >= 0; i--) zlz[i] = zlz[i+1] && disp_nx[4*i +: 4] == 4'h0;
    en = !blank_nx && !(blank_lz && sel_nx != '0 && zlz[sel_nx]);
    nib_nx = disp_nx[{sel_nx, 2'b00} +: 4];
  end
  // buffers and registered outputs; pend is swapped into disp only at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp <= '0;
      pend_vld <= 1'b0;
      disp <= '0;
      disp_dp <= '0;
      digit_nib <= '0;
      an <= {N_DIGITS{AN_OFF}};
      dp <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      disp <= disp_nx;
      disp_dp <= disp_dp_nx;
      if (boundary) pend_vld <= 1'b0;
      else if (load) begin
        pend_val <= value;
        pend_dp <= dp_in;
        pend_vld <= 1'b1;
      end
      digit_nib <= nib_nx;
      an <= en ? ~({{(N_DIGITS-1){1'b0}}, 1'b1} << sel_nx) : {N_DIGITS{AN_OFF}};
      dp <= en ? ~disp_dp_nx[sel_nx] : 1'b1;
      frame_done <= boundary;
    end
  end
endmodule
